data_memory_arbiter: RTL
========================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter dataWidth, default 64, meaning width of write/read data on all ports.
REQ-002 SHALL have parameter addressWidth, default 64, meaning width of all address buses.
REQ-003 SHALL have parameter accessCycles, default 2, legal range 1..15, meaning cycles the memory strobe is held per transaction.
REQ-004 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req0_valid/req1_valid  input  1  requester N presents a transaction.
REQ-007 SHALL have ports req0_write/req1_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports req0_address/req1_address  input  addressWidth  transaction address.
REQ-009 SHALL have ports req0_write_data/req1_write_data  input  dataWidth  write payload.
REQ-010 SHALL have ports req0_ready/req1_ready  output  1  requester N's transaction is accepted this cycle.
REQ-011 SHALL have ports rsp0_valid/rsp1_valid  output  1  one-cycle completion pulse for requester N.
REQ-012 SHALL have ports rsp0_read_data/rsp1_read_data  output  dataWidth  read result, qualified by rspN_valid.
REQ-013 SHALL have ports mem_read, mem_write  output  1  registered strobes to the data memory.
REQ-014 SHALL have port mem_address  output  addressWidth  registered; mem_write_data  output  dataWidth  registered.
REQ-015 SHALL have port mem_read_data  input  dataWidth  data returned by the memory.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-017 IDLE: reqN_ready SHALL be asserted combinationally only to the arbitration winner among valid requesters; no ready when neither is valid.
REQ-018 On a cycle in IDLE with reqN_valid & reqN_ready, SHALL latch address, write_data, write flag and grant owner, and go to ACCESS.
REQ-019 ACCESS: SHALL hold mem_read (read) or mem_write (write), mem_address, mem_write_data constant for exactly accessCycles cycles; exactly one strobe is high.
REQ-020 On the last ACCESS cycle SHALL capture mem_read_data into an internal register (reads only), deassert strobes at the next edge, and go to DONE.
REQ-021 DONE: SHALL assert rspN_valid of the grant owner for exactly one cycle, then return to IDLE; rsp_read_data SHALL equal the captured value for reads and 0 for writes.
REQ-022 Both reqN_ready SHALL be 0 in ACCESS and DONE; requests SHALL stay pending (valid held by requester) without loss.
REQ-023 Transaction latency SHALL be accessCycles+2 cycles from accept edge to rspN_valid cycle; back-to-back throughput one transaction per accessCycles+2 cycles.
REQ-024 rspN_read_data of the non-owner SHALL be 0; rsp0_valid and rsp1_valid SHALL never both be 1.
REQ-025 Strobe counter SHALL be 4 bits, load accessCycles-1 on accept, decrement in ACCESS, with no wrap-around.

Reset
REQ-026 With reset high at a rising edge, SHALL enter IDLE and clear mem_read, mem_write, mem_address, mem_write_data, rsp0/1_valid, rsp0/1_read_data, counter and captured data to 0.
REQ-027 The arbitration pointer SHALL reset so that requester 0 wins the first contested grant.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no rspN_valid; strobes are low from the cycle after the reset edge.
REQ-029 reqN_ready SHALL be 0 in every cycle reset is high.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous valid, SHALL grant the requester not granted last; a single valid requester always wins.
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: requester 0 SHALL have fixed priority whenever both are valid; pointer logic absent.

Verification
REQ-032 Reset, then req0 write addr 5 data 0xAA -> mem_write high 2 cycles with mem_address 5, rsp0_valid one cycle 4 cycles after accept, rsp0_read_data 0.
REQ-033 After REQ-032, req1 read addr 5 -> mem_read high 2 cycles, rsp1_valid with rsp1_read_data 0xAA, rsp0_valid stays 0.
REQ-034 Both valid continuously with ARB_ROUND_ROBIN_EN -> grants 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-035 reset asserted on the 2nd ACCESS cycle of a read -> next cycle IDLE, strobes 0, no rsp pulse; a held request is then re-accepted.
REQ-036 accessCycles=1, 3 back-to-back reads on req0 -> strobe 1 cycle each, rsp0_valid every 3rd cycle, never both rsp valid high.

Source files
------------

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the data memory.
// slave: arbiter side; master: requester/memory side.
interface data_memory_arbiter_if #(
  parameter int dataWidth    = 64,
  parameter int addressWidth = 64
);
  logic                    req0_valid;
  logic                    req0_write;
  logic [addressWidth-1:0] req0_address;
  logic [dataWidth-1:0]    req0_write_data;
  logic                    req0_ready;
  logic                    req1_valid;
  logic                    req1_write;
  logic [addressWidth-1:0] req1_address;
  logic [dataWidth-1:0]    req1_write_data;
  logic                    req1_ready;
  logic                    rsp0_valid;
  logic [dataWidth-1:0]    rsp0_read_data;
  logic                    rsp1_valid;
  logic [dataWidth-1:0]    rsp1_read_data;
  logic                    mem_read;
  logic                    mem_write;
  logic [addressWidth-1:0] mem_address;
  logic [dataWidth-1:0]    mem_write_data;
  logic [dataWidth-1:0]    mem_read_data;

  modport slave (
    input  req0_valid, req0_write,
    input  req0_address, req0_write_data,
    input  req1_valid, req1_write,
    input  req1_address, req1_write_data,
    input  mem_read_data,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_read_data,
    output rsp1_valid, rsp1_read_data,
    output mem_read, mem_write,
    output mem_address, mem_write_data
  );

  modport master (
    output req0_valid, req0_write,
    output req0_address, req0_write_data,
    output req1_valid, req1_write,
    output req1_address, req1_write_data,
    output mem_read_data,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_read_data,
    input  rsp1_valid, rsp1_read_data,
    input  mem_read, mem_write,
    input  mem_address, mem_write_data
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter for a single-port data memory.
// Ports: clock, reset (sync, active high), bus (slave modport).
// Macro ARB_ROUND_ROBIN_EN: round-robin on contention,
// otherwise requester 0 has fixed priority.
module data_memory_arbiter #(
  parameter int dataWidth    = 64,
  parameter int addressWidth = 64,
  parameter int accessCycles = 2
) (
  input logic                  clock,
  input logic                  reset,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] LOAD = 4'(accessCycles - 1);

  state_t               state;
  logic [3:0]           count;
  logic                 owner;
  logic                 wr_q;
  logic [dataWidth-1:0] captured;
  logic                 rsp0_q;
  logic                 rsp1_q;
  logic                 grant0;
  logic                 grant1;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = requester 1 won the last grant, so 0 goes first after reset
  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end
`else
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid && !bus.req0_valid;
  end
`endif

  assign bus.req0_ready = (state == IDLE) && !reset && grant0;
  assign bus.req1_ready = (state == IDLE) && !reset && grant1;

  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  // writes and the idle requester see zero data
  assign bus.rsp0_read_data = (rsp0_q && !wr_q) ? captured : '0;
  assign bus.rsp1_read_data = (rsp1_q && !wr_q) ? captured : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      count              <= 4'd0;
      owner              <= 1'b0;
      wr_q               <= 1'b0;
      captured           <= '0;
      rsp0_q             <= 1'b0;
      rsp1_q             <= 1'b0;
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_address    <= {addressWidth{1'b0}};
      bus.mem_write_data <= {dataWidth{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
      last_grant         <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant0: begin
              owner              <= 1'b0;
              wr_q               <= bus.req0_write;
              bus.mem_address    <= bus.req0_address;
              bus.mem_write_data <= bus.req0_write_data;
              bus.mem_read       <= !bus.req0_write;
              bus.mem_write      <= bus.req0_write;
              count              <= LOAD;
              state              <= ACCESS;
            end
            grant1: begin
              owner              <= 1'b1;
              wr_q               <= bus.req1_write;
              bus.mem_address    <= bus.req1_address;
              bus.mem_write_data <= bus.req1_write_data;
              bus.mem_read       <= !bus.req1_write;
              bus.mem_write      <= bus.req1_write;
              count              <= LOAD;
              state              <= ACCESS;
            end
            default: ;
          endcase
`ifdef ARB_ROUND_ROBIN_EN
          if (grant0 || grant1) begin
            last_grant <= grant1;
          end
`endif
        end
        ACCESS: begin
          if (count == 4'd0) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (!wr_q) begin
              captured <= bus.mem_read_data;
            end
            rsp0_q <= !owner;
            rsp1_q <= owner;
            state  <= DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE: begin
          rsp0_q <= 1'b0;
          rsp1_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
